dsm_sample_sequencer: RTL and testbench

Sequences sample delivery into the order-1 DSM DAC datapath (top_dsm_dac_older_1). It buffers incoming signed samples from an upstream valid/ready source in a small FIFO. It generates the one-cycle i_sample strobe at a programmable oversampling ratio (OSR) and presents the sample to the modulator's i_data. It handles start-up priming, underflow, and stop/flush, so the modulator always sees a defined input.

---
 rtl/dsm_sample_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_dsm_sample_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_sample_sequencer.sv
// dsm_sample_sequencer
// Feeds buffered signed samples to an order-1 DSM DAC. An 8-entry FIFO takes
// samples from an upstream valid/ready source. In RUN, a phase counter issues
// a one-cycle sample strobe every osr_q clocks. Each strobe loads the FIFO
// head, or loads 0 and flags underflow when the FIFO is empty. Dropping
// i_enable flushes the FIFO and parks the outputs at 0.
module dsm_sample_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OSR_WIDTH  = 16,
  parameter int FIFO_AW    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [OSR_WIDTH-1:0]  i_osr,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_sample,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_running,
  output logic                  o_underflow,
  output logic [15:0]           o_underflow_count,
  output logic [FIFO_AW:0]      o_level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]     LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]     LVL_PRIME = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0]     LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0]   PTR_ONE   = FIFO_AW'(1);
  localparam logic [OSR_WIDTH-1:0] OSR_ONE   = OSR_WIDTH'(1);
  localparam logic [15:0]          UFC_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [OSR_WIDTH-1:0]    osr_q, osr_d;
  logic [OSR_WIDTH-1:0]    phase_q, phase_d;
  logic                    sample_q, sample_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    uf_q, uf_d;
  logic [15:0]             ufc_q, ufc_d;
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]        level_q, level_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic s_ready;
  logic push;
  logic pop;
  logic flush;

  // Ready depends only on registered state, so upstream never sees a comb path.
  assign s_ready = (state_q != ST_IDLE) && (level_q < LVL_FULL);

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) so all registers update
  // from the same pre-edge values; blocking here would create order races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: stop always wins, PRIME waits for a half-full FIFO.
  // NOTE: each combinational block assigns a default to every output first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_enable) state_d = ST_PRIME;
      ST_PRIME: begin
        if (!i_enable)                  state_d = ST_IDLE;
        else if (level_q >= LVL_PRIME)  state_d = ST_RUN;
      end
      ST_RUN:   if (!i_enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: next values for the registered outputs, FIFO controls.
  always_comb begin
    osr_d    = osr_q;
    phase_d  = phase_q;
    sample_d = 1'b0;
    data_d   = data_q;
    uf_d     = 1'b0;
    ufc_d    = ufc_q;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        flush   = 1'b1;
        data_d  = '0;
        phase_d = '0;
        // 0 and 1 both mean one strobe per clock.
        if (i_enable) osr_d = (i_osr == '0) ? OSR_ONE : i_osr;
      end
      ST_PRIME: begin
        phase_d = '0;
        if (!i_enable) begin
          flush  = 1'b1;
          data_d = '0;
        end else begin
          push = i_s_valid && s_ready;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          flush   = 1'b1;
          data_d  = '0;
          phase_d = '0;
        end else begin
          push = i_s_valid && s_ready;
          if (phase_q == osr_q - OSR_ONE) begin
            phase_d  = '0;
            sample_d = 1'b1;
            if (level_q != '0) begin
              pop    = 1'b1;
              data_d = mem[rd_ptr_q];
            end else begin
              data_d = '0;
              uf_d   = 1'b1;
              if (ufc_q != UFC_MAX) ufc_d = ufc_q + 16'd1;
            end
          end else begin
            phase_d = phase_q + OSR_ONE;
          end
        end
      end
      default: begin
        flush  = 1'b1;
        data_d = '0;
      end
    endcase
  end

  // FIFO pointer/occupancy update; a full FIFO has s_ready low, so a
  // same-edge pop can never let a push in.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      osr_q    <= OSR_ONE;
      phase_q  <= '0;
      sample_q <= 1'b0;
      data_q   <= '0;
      uf_q     <= 1'b0;
      ufc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      osr_q    <= osr_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      data_q   <= data_d;
      uf_q     <= uf_d;
      ufc_q    <= ufc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; level_q gates every read, so stale
  // contents are never observed, and leaving it out keeps it a plain RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_s_data;
  end

  assign o_s_ready         = s_ready;
  assign o_sample          = sample_q;
  assign o_data            = data_q;
  assign o_running         = (state_q == ST_RUN);
  assign o_underflow       = uf_q;
  assign o_underflow_count = ufc_q;
  assign o_level           = level_q;

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// Self-checking bench for dsm_sample_sequencer. Accepted samples go into a
// scoreboard queue; each strobe pops the expected value, or expects 0 with
// underflow when nothing was buffered before that edge.
module tb_dsm_sample_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable;
  logic [15:0] i_osr;
  logic        i_s_valid;
  logic [7:0]  i_s_data;
  logic        o_s_ready;
  logic        o_sample;
  logic [7:0]  o_data;
  logic        o_running;
  logic        o_underflow;
  logic [15:0] o_underflow_count;
  logic [3:0]  o_level;

  int          total = 0;
  int          bad   = 0;
  int          exp_ufc = 0;
  logic [7:0]  q[$];

  dsm_sample_sequencer #(.DATA_WIDTH(8), .OSR_WIDTH(16), .FIFO_AW(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_osr(i_osr),
    .i_s_valid(i_s_valid), .i_s_data(i_s_data), .o_s_ready(o_s_ready),
    .o_sample(o_sample), .o_data(o_data), .o_running(o_running),
    .o_underflow(o_underflow), .o_underflow_count(o_underflow_count),
    .o_level(o_level)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; updates the scoreboard and returns what to expect.
  task automatic cyc(input logic en, input logic vld, input logic [7:0] d,
                     output logic acc, output logic [7:0] exp_d, output logic exp_uf);
    int pre;
    i_enable  = en;
    i_s_valid = vld;
    i_s_data  = d;
    pre = q.size();
    acc = vld && o_s_ready && en;
    @(posedge i_clk);
    #1;
    exp_d  = 8'h00;
    exp_uf = 1'b0;
    if (o_sample) begin
      if (pre > 0) exp_d = q.pop_front();
      else begin
        exp_uf = 1'b1;
        exp_ufc++;
      end
    end
    if (acc) q.push_back(d);
    if (!en) q.delete();
  endtask

  task automatic test_reset();
    logic acc; logic [7:0] ed; logic eu;
    i_rst_n = 1'b0; i_enable = 1'b0; i_s_valid = 1'b1; i_s_data = 8'hAA; i_osr = 16'd4;
    repeat (3) @(posedge i_clk);
    #1;
    total++;
    if ({o_s_ready, o_sample, o_data, o_running, o_underflow, o_underflow_count, o_level} !== '0) begin
      bad++;
      $display("FAIL reset_values: got rdy=%0b smp=%0b data=%0h lvl=%0d cnt=%0d want all 0",
               o_s_ready, o_sample, o_data, o_level, o_underflow_count);
    end
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 8'hAA, acc, ed, eu);
      total++;
      if ({o_s_ready, o_sample, o_data, o_level, o_running} !== '0) begin
        bad++;
        $display("FAIL idle_quiet[%0d]: got rdy=%0b smp=%0b data=%0h lvl=%0d want 0 0 0 0",
                 i, o_s_ready, o_sample, o_data, o_level);
      end
    end
  endtask

  task automatic test_prime_cadence();
    logic acc; logic [7:0] ed; logic eu;
    logic [7:0] vals [4];
    logic [7:0] last;
    logic       exp_s;
    vals = '{8'h05, 8'h7F, 8'h80, 8'hFF};
    i_osr = 16'd4;
    cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
    total++;
    if (o_running !== 1'b0 || o_s_ready !== 1'b1) begin
      bad++;
      $display("FAIL prime_entry: got run=%0b rdy=%0b want 0 1", o_running, o_s_ready);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, vals[k], acc, ed, eu);
      total++;
      if (o_level !== 4'(k + 1) || o_running !== 1'b0) begin
        bad++;
        $display("FAIL prime_push[%0d]: got lvl=%0d run=%0b want %0d 0", k, o_level, o_running, k + 1);
      end
    end
    cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
    total++;
    if (o_running !== 1'b1 || o_level !== 4'd4 || o_sample !== 1'b0) begin
      bad++;
      $display("FAIL run_entry: got run=%0b lvl=%0d smp=%0b want 1 4 0", o_running, o_level, o_sample);
    end
    last = 8'h00;
    for (int n = 1; n <= 16; n++) begin
      cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
      exp_s = (n % 4 == 0);
      total++;
      if (o_sample !== exp_s || o_underflow !== 1'b0) begin
        bad++;
        $display("FAIL cadence[%0d]: got smp=%0b uf=%0b want %0b 0", n, o_sample, o_underflow, exp_s);
      end
      if (exp_s) begin
        total++;
        if (o_data !== vals[n / 4 - 1] || o_data !== ed) begin
          bad++;
          $display("FAIL strobe_data[%0d]: got %0h want %0h", n, o_data, vals[n / 4 - 1]);
        end
        last = vals[n / 4 - 1];
      end else begin
        total++;
        if (o_data !== last) begin
          bad++;
          $display("FAIL data_hold[%0d]: got %0h want %0h", n, o_data, last);
        end
      end
    end
  endtask

  task automatic test_underflow();
    logic acc; logic [7:0] ed; logic eu;
    logic exp_s;
    for (int n = 17; n <= 32; n++) begin
      cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
      exp_s = (n % 4 == 0);
      total++;
      if (o_sample !== exp_s || o_underflow !== exp_s) begin
        bad++;
        $display("FAIL uf_pulse[%0d]: got smp=%0b uf=%0b want %0b %0b", n, o_sample, o_underflow, exp_s, exp_s);
      end
      if (exp_s) begin
        total++;
        if (o_data !== 8'h00 || eu !== 1'b1) begin
          bad++;
          $display("FAIL uf_data[%0d]: got %0h want 0", n, o_data);
        end
      end
    end
    total++;
    if (o_underflow_count !== 16'd4 || o_running !== 1'b1) begin
      bad++;
      $display("FAIL uf_count: got cnt=%0d run=%0b want 4 1", o_underflow_count, o_running);
    end
  endtask

  task automatic test_full();
    logic acc; logic [7:0] ed; logic eu;
    logic [7:0] nd;
    logic       reached;
    int         ns;
    int         acc_cnt;
    cyc(1'b0, 1'b0, 8'h00, acc, ed, eu);
    total++;
    if (o_level !== 4'd0 || o_running !== 1'b0) begin
      bad++;
      $display("FAIL full_stop: got lvl=%0d run=%0b want 0 0", o_level, o_running);
    end
    i_osr = 16'd100;
    cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
    nd = 8'h10;
    reached = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cyc(1'b1, 1'b1, nd, acc, ed, eu);
      if (acc) nd++;
      if (o_level > 4'd8) begin
        total++; bad++;
        $display("FAIL level_bound: got %0d want <=8", o_level);
      end
      if (o_level == 4'd8 && !reached) begin
        reached = 1'b1;
        total++;
        if (o_s_ready !== 1'b0) begin
          bad++;
          $display("FAIL full_ready: got %0b want 0", o_s_ready);
        end
      end
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL level_full: got lvl=%0d want 8", o_level);
    end
    ns = 0;
    acc_cnt = 0;
    for (int c = 0; c < 400 && ns < 3; c++) begin
      cyc(1'b1, 1'b1, nd, acc, ed, eu);
      if (acc) begin
        nd++;
        acc_cnt++;
      end
      if (o_sample) begin
        total++;
        if (o_data !== ed || o_level !== 4'd7 || eu !== 1'b0) begin
          bad++;
          $display("FAIL full_strobe[%0d]: got data=%0h lvl=%0d want %0h 7", ns, o_data, o_level, ed);
        end
        if (ns > 0) begin
          total++;
          if (acc_cnt != 1) begin
            bad++;
            $display("FAIL accept_per_strobe[%0d]: got %0d want 1", ns, acc_cnt);
          end
        end
        acc_cnt = 0;
        ns++;
      end
    end
    total++;
    if (ns != 3) begin
      bad++;
      $display("FAIL full_timeout: got %0d strobes want 3", ns);
    end
  endtask

  task automatic test_osr_edges();
    logic acc; logic [7:0] ed; logic eu;
    logic [7:0] nd;
    logic [3:0] lvl;
    int         waited;
    logic [15:0] osrs [2];
    osrs = '{16'd0, 16'd1};
    nd = 8'hC0;
    for (int s = 0; s < 2; s++) begin
      cyc(1'b0, 1'b0, 8'h00, acc, ed, eu);
      i_osr = osrs[s];
      cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
      waited = 0;
      while (!o_running && waited < 20) begin
        cyc(1'b1, 1'b1, nd, acc, ed, eu);
        if (acc) nd++;
        waited++;
      end
      total++;
      if (!o_running) begin
        bad++;
        $display("FAIL osr%0d_run_timeout: got run=%0b want 1", osrs[s], o_running);
      end
      lvl = o_level;
      for (int c = 0; c < 12; c++) begin
        cyc(1'b1, 1'b1, nd, acc, ed, eu);
        if (acc) nd++;
        total++;
        if (o_sample !== 1'b1 || o_data !== ed || o_level !== lvl || o_underflow !== 1'b0) begin
          bad++;
          $display("FAIL osr%0d_every_cycle[%0d]: got smp=%0b data=%0h lvl=%0d want 1 %0h %0d",
                   osrs[s], c, o_sample, o_data, o_level, ed, lvl);
        end
      end
    end
  endtask

  task automatic test_stop_reset();
    logic acc; logic [7:0] ed; logic eu;
    cyc(1'b0, 1'b0, 8'h00, acc, ed, eu);
    i_osr = 16'd50;
    cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 8'(8'h40 + k), acc, ed, eu);
    total++;
    if (o_running !== 1'b1 || o_level !== 4'd5) begin
      bad++;
      $display("FAIL stop_setup: got run=%0b lvl=%0d want 1 5", o_running, o_level);
    end
    cyc(1'b0, 1'b1, 8'h99, acc, ed, eu);
    total++;
    if (o_running !== 1'b0 || o_level !== 4'd0 || o_data !== 8'h00 || o_sample !== 1'b0 || o_s_ready !== 1'b0) begin
      bad++;
      $display("FAIL stop_flush: got run=%0b lvl=%0d data=%0h smp=%0b rdy=%0b want 0 0 0 0 0",
               o_running, o_level, o_data, o_sample, o_s_ready);
    end
    cyc(1'b1, 1'b0, 8'h00, acc, ed, eu);
    total++;
    if (o_running !== 1'b0 || o_s_ready !== 1'b1 || o_underflow_count !== 16'(exp_ufc)) begin
      bad++;
      $display("FAIL restart_count: got run=%0b rdy=%0b cnt=%0d want 0 1 %0d",
               o_running, o_s_ready, o_underflow_count, exp_ufc);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_s_ready, o_sample, o_data, o_running, o_underflow, o_underflow_count, o_level} !== '0) begin
      bad++;
      $display("FAIL async_reset: got rdy=%0b run=%0b lvl=%0d cnt=%0d want all 0",
               o_s_ready, o_running, o_level, o_underflow_count);
    end
    i_enable = 1'b0;
    i_s_valid = 1'b0;
    q.delete();
    @(negedge i_clk) i_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_prime_cadence();
    test_underflow();
    test_full();
    test_osr_edges();
    test_stop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
